// File: rtl/rr_mux_8x1.sv
// -----------------------------------------------------------------------------
// rr_mux_8x1
//
// Round-robin 8-to-1 stream multiplexer. Eight independent valid/ready lanes
// are merged into one output stream through a single registered output stage.
// Each output beat carries the index of the lane it came from, so a downstream
// 8-way demux can route it back out by index.
//
// Ports
//   clk        in   1         rising-edge clock for all state
//   rst        in   1         synchronous, active-high reset
//   in_valid   in   [0:7]     lane i has a beat pending (bit i = lane i)
//   in_data    in   8*WIDTH   lane i data at bits [i*WIDTH +: WIDTH]
//   in_ready   out  [0:7]     lane i beat is consumed this cycle (one-hot or 0)
//   out_valid  out  1         output register holds a beat
//   out_data   out  WIDTH     data of the held beat
//   out_sel    out  [0:2]     source lane of the held beat, out_sel[0] is MSB
//   out_ready  in   1         downstream accepts the held beat this cycle
//
// Arbitration starts the scan one lane past the last granted lane, so every
// continuously valid lane is served at least once every eight accepted beats.
// The pointer moves only on a real grant, which keeps backpressure from
// skipping any lane.
// -----------------------------------------------------------------------------
module rr_mux_8x1 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [0:7]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [0:7]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [0:2]         out_sel,
  input  logic               out_ready
);

  // ---------------------------------------------------------------------------
  // Round-robin pick: first requesting lane in the order last+1 .. last+8,
  // with 3-bit wrap. Returns last itself when only that lane requests (k = 8
  // wraps back to it). The caller qualifies the result with "any request".
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] rr_pick(input logic [0:7] req,
                                         input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    logic [2:0] pick;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + k[2:0];
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------------------
  // One-hot decode of a lane index into the lane-ordered [0:7] vector.
  // ---------------------------------------------------------------------------
  function automatic logic [0:7] lane_onehot(input logic [2:0] lane);
    logic [0:7] v;
    v       = 8'h00;
    v[lane] = 1'b1;
    return v;
  endfunction

  // State
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [2:0]       out_sel_r;
  logic [2:0]       ptr_r;

  // Combinational helpers
  logic             load_s;
  logic             any_valid_s;
  logic [2:0]       grant_s;
  logic [0:7]       ready_s;
  logic [WIDTH-1:0] grant_data_s;

  // Output register may take a new beat when empty or being drained now.
  assign load_s      = ~out_valid_r | out_ready;
  assign any_valid_s = |in_valid;

  // Grant selection from valid lanes and the last-granted pointer only.
  always_comb begin
    grant_s = rr_pick(in_valid, ptr_r);
  end

  // Lane handshake: only the granted lane sees ready, and never during reset.
  always_comb begin
    ready_s = 8'h00;
    if (!rst && load_s && any_valid_s) begin
      ready_s = lane_onehot(grant_s);
    end else begin
      ready_s = 8'h00;
    end
  end

  // Data mux for the granted lane; a loop keeps the part-select constant.
  always_comb begin
    grant_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < 8; i++) begin
      if (grant_s == i[2:0]) begin
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // Output register and round-robin pointer. Reset discards any held beat and
  // parks the pointer on lane 7 so lane 0 is scanned first.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= 3'd0;
      ptr_r       <= 3'd7;
    end else if (load_s) begin
      if (any_valid_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= grant_data_s;
        out_sel_r   <= grant_s;
        ptr_r       <= grant_s;
      end else begin
        // Drained with nothing to refill: data, select and pointer keep
        // their last values so the pointer only ever moves on a grant.
        out_valid_r <= 1'b0;
      end
    end else begin
      // Held beat not accepted: everything stays put.
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_mux_8x1.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_8x1
//
// Directed bench for rr_mux_8x1. Inputs are driven 2 time units after a rising
// edge and all observations are taken 1 unit later, mid-cycle. Registered
// outputs therefore show the result of the edge just passed, and in_ready
// shows the handshake that the next edge will act on.
// -----------------------------------------------------------------------------
module tb_rr_mux_8x1;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [0:7]         in_valid;
  logic [8*WIDTH-1:0] in_data;
  logic [0:7]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [0:2]         out_sel;
  logic               out_ready;

  int total;
  int bad;

  rr_mux_8x1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [0:7] lane(input int i);
    logic [0:7] v;
    v    = 8'h00;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] d);
    in_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_valid  = 8'hFF;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_lane(i, 8'(8'h10 + i));
    rst = 1'b1;
    tick();
    tick();
    settle();
    total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL reset_in_ready got=%b exp=%b", in_ready, 8'h00); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_sel !== 3'b000) begin bad++; $display("FAIL reset_out_sel got=%b exp=000", out_sel); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    rst       = 1'b0;
    out_ready = 1'b1;
    settle();
    total++; if (in_ready !== lane(0)) begin bad++; $display("FAIL reset_first_ready got=%b exp=%b", in_ready, lane(0)); end
    tick();
    settle();
    total++; if (out_valid !== 1'b1 || out_sel !== 3'b000 || out_data !== 8'h10) begin
      bad++; $display("FAIL reset_first_beat got=%b/%b/%h exp=1/000/10", out_valid, out_sel, out_data);
    end
    in_valid = 8'h00;
    tick();
    settle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_single();
    set_lane(5, 8'hA5);
    in_valid  = lane(5);
    out_ready = 1'b1;
    settle();
    total++; if (in_ready !== lane(5)) begin bad++; $display("FAIL single_ready got=%b exp=%b", in_ready, lane(5)); end
    tick();
    in_valid = 8'h00;
    settle();
    total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL single_ready_drop got=%b exp=00000000", in_ready); end
    total++; if (out_valid !== 1'b1 || out_sel !== 3'b101 || out_data !== 8'hA5) begin
      bad++; $display("FAIL single_beat got=%b/%b/%h exp=1/101/a5", out_valid, out_sel, out_data);
    end
    tick();
    settle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_rotation();
    do_reset();
    for (int i = 0; i < 8; i++) set_lane(i, 8'(8'h10 + i));
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      settle();
      total++; if (in_ready !== lane(k % 8)) begin bad++; $display("FAIL rot_ready[%0d] got=%b exp=%b", k, in_ready, lane(k % 8)); end
      tick();
      settle();
      total++; if (out_valid !== 1'b1 || out_sel !== 3'(k % 8) || out_data !== 8'(8'h10 + (k % 8))) begin
        bad++; $display("FAIL rot_beat[%0d] got=%b/%b/%h exp=1/%b/%h", k, out_valid, out_sel, out_data, 3'(k % 8), 8'(8'h10 + (k % 8)));
      end
    end
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_backpressure();
    // Pointer is on lane 0 here, so lane 2 wins first.
    set_lane(2, 8'h22);
    set_lane(6, 8'h66);
    in_valid  = lane(2) | lane(6);
    out_ready = 1'b1;
    settle();
    total++; if (in_ready !== lane(2)) begin bad++; $display("FAIL bp_first_ready got=%b exp=%b", in_ready, lane(2)); end
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL bp_hold_ready[%0d] got=%b exp=00000000", c, in_ready); end
      total++; if (out_valid !== 1'b1 || out_sel !== 3'b010 || out_data !== 8'h22) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%b/%h exp=1/010/22", c, out_valid, out_sel, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    settle();
    total++; if (in_ready !== lane(6)) begin bad++; $display("FAIL bp_release_ready got=%b exp=%b", in_ready, lane(6)); end
    tick();
    settle();
    total++; if (out_sel !== 3'b110 || out_data !== 8'h66) begin bad++; $display("FAIL bp_lane6 got=%b/%h exp=110/66", out_sel, out_data); end
    tick();
    settle();
    total++; if (out_sel !== 3'b010 || out_data !== 8'h22) begin bad++; $display("FAIL bp_lane2 got=%b/%h exp=010/22", out_sel, out_data); end
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    set_lane(0, 8'h0F);
    set_lane(7, 8'h7E);
    in_valid  = lane(7);
    out_ready = 1'b1;
    tick();
    settle();
    total++; if (out_sel !== 3'b111 || out_data !== 8'h7E) begin bad++; $display("FAIL wrap_setup got=%b/%h exp=111/7e", out_sel, out_data); end
    in_valid = lane(0) | lane(7);
    settle();
    total++; if (in_ready !== lane(0)) begin bad++; $display("FAIL wrap_ready got=%b exp=%b", in_ready, lane(0)); end
    tick();
    settle();
    total++; if (out_sel !== 3'b000 || out_data !== 8'h0F) begin bad++; $display("FAIL wrap_lane0 got=%b/%h exp=000/0f", out_sel, out_data); end
    tick();
    settle();
    total++; if (out_sel !== 3'b111 || out_data !== 8'h7E) begin bad++; $display("FAIL wrap_lane7 got=%b/%h exp=111/7e", out_sel, out_data); end
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid();
    set_lane(3, 8'h33);
    set_lane(0, 8'hC0);
    set_lane(4, 8'hC4);
    in_valid  = lane(3);
    out_ready = 1'b0;
    tick();
    in_valid = 8'h00;
    settle();
    total++; if (out_valid !== 1'b1 || out_sel !== 3'b011) begin bad++; $display("FAIL mid_setup got=%b/%b exp=1/011", out_valid, out_sel); end
    rst      = 1'b1;
    in_valid = 8'hFF;
    settle();
    total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL mid_rst_ready got=%b exp=00000000", in_ready); end
    tick();
    rst      = 1'b0;
    in_valid = 8'h00;
    settle();
    total++; if (out_valid !== 1'b0 || out_sel !== 3'b000 || out_data !== 8'h00) begin
      bad++; $display("FAIL mid_lost got=%b/%b/%h exp=0/000/00", out_valid, out_sel, out_data);
    end
    in_valid  = lane(0) | lane(4);
    out_ready = 1'b1;
    settle();
    total++; if (in_ready !== lane(0)) begin bad++; $display("FAIL mid_ready0 got=%b exp=%b", in_ready, lane(0)); end
    tick();
    settle();
    total++; if (out_sel !== 3'b000 || out_data !== 8'hC0) begin bad++; $display("FAIL mid_lane0 got=%b/%h exp=000/c0", out_sel, out_data); end
    total++; if (in_ready !== lane(4)) begin bad++; $display("FAIL mid_ready4 got=%b exp=%b", in_ready, lane(4)); end
    tick();
    settle();
    total++; if (out_sel !== 3'b100 || out_data !== 8'hC4) begin bad++; $display("FAIL mid_lane4 got=%b/%h exp=100/c4", out_sel, out_data); end
    in_valid = 8'h00;
    tick();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 8'h00;
    in_data   = '0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_8x1.md
# rr_mux_8x1

Round-robin 8-to-1 stream multiplexer: the collecting counterpart of the 8-way demux, merging eight independent valid/ready lanes into one output stream. Each output beat carries the source lane index on `out_sel`, so a downstream demux can route it back out by index. Grants are fair round-robin with a single registered output stage, giving one beat per cycle of sustained throughput.

## Interface
- `WIDTH`, default 8: data bits per lane and on the output.

- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  [0:7]  lane i has a beat pending.
- `in_data`  in  8*WIDTH  lane i data at bits [i*WIDTH +: WIDTH].
- `in_ready`  out  [0:7]  lane i beat is consumed this cycle; at most one bit high.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  WIDTH  data of the held beat.
- `out_sel`  out  [0:2]  source lane index of the held beat; `out_sel[0]` is the MSB, same encoding as the demux select.
- `out_ready`  in  1  downstream accepts the beat this cycle.

## Operation
- State: the output register (`out_valid`, `out_data`, `out_sel`) and a 3-bit pointer `ptr` holding the last granted lane.
- Load enable: `load = ~out_valid | out_ready`.
- Arbitration: scan lanes `ptr+1, ptr+2, ... ptr+8` modulo 8. The first lane with `in_valid` high is the grant `g`. Pointer arithmetic is 3-bit and wraps 7 -> 0.
- `in_ready[g] = load & any(in_valid)`. All other `in_ready` bits are 0. `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and `ptr`. It never depends on `in_data`.
- Transfer on lane i happens when `in_valid[i] & in_ready[i]`.
- On clock edge with `load` high and a grant present: `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`, `ptr <= g`.
- On clock edge with `load` high and no lane valid: `out_valid <= 0`. `out_data`, `out_sel` and `ptr` are unchanged.
- On clock edge with `load` low (output held, not accepted): all state is unchanged and all `in_ready` bits are 0.
- Fairness: a continuously valid lane waits at most 7 accepted beats between grants.
- No lane is starved by backpressure. `ptr` advances only on an actual grant.

## Timing
- Reset, sampled on a `clk` edge with `rst` high:
  - `out_valid = 0`, `out_data = 0`, `out_sel = 3'b000`.
  - `ptr = 7`, so lane 0 has first priority after reset.
  - `in_ready = 0` while `rst` is high, regardless of `in_valid`.
- `rst` has priority over every other event, including a pending unaccepted beat; that beat is discarded.
- Latency: a beat accepted on a lane at edge N is presented on the output with `out_valid` high from edge N until the cycle after `out_ready` is sampled high.
- Throughput: with `out_ready` held high and at least one lane valid every cycle, `out_valid` stays high and one beat moves per cycle.
- Simultaneous accept and refill: if `out_valid & out_ready` coincide with a valid lane, the new beat replaces the old one at the same edge with no bubble.
- Output stability: while `out_valid & ~out_ready`, `out_data` and `out_sel` hold constant.
- `in_valid` may drop without a transfer. The arbiter re-evaluates every cycle and makes no commitment before the edge.

## Test plan
- Reset: hold `rst` high for 2 cycles with all `in_valid = 8'hFF` -> `in_ready = 0`, `out_valid = 0`, `out_sel = 000`, `out_data = 0`. After release, the first beat comes from lane 0.
- Single lane: lane 5 valid with `0xA5`, `out_ready = 1` -> `in_ready[5]` high for exactly that cycle. Next cycle `out_valid = 1`, `out_sel = 101`, `out_data = 0xA5`. The cycle after that `out_valid = 0`.
- Full rotation: all lanes valid continuously, lane i data `= 0x10 + i`, `out_ready = 1` -> `out_sel` sequence 000, 001, ... 111, 000 on consecutive cycles, each paired with its data and no bubbles.
- Backpressure: lanes 2 and 6 valid, `out_ready = 0` for 3 cycles after lane 2 is loaded -> output holds `out_sel = 010` and `in_ready = 0`. Release `out_ready` -> lane 6 is granted next, then lane 2.
- Wrap-around: last grant was lane 7, lanes 0 and 7 valid -> lane 0 is granted (`out_sel = 000`) before lane 7.
- Reset mid-operation: `out_valid = 1`, `out_ready = 0`, `ptr = 3`, assert `rst` for 1 cycle -> next cycle `out_valid = 0` and the held beat is lost. With lanes 0 and 4 valid afterwards, lane 0 is granted first.
